// File: rtl/types_pkg.sv
// Shared datapath types for the register file and its write-back path.
package types_pkg;

  localparam int REG_COUNT  = 32;
  localparam int ADDR_W     = $clog2(REG_COUNT);
  localparam int WORD_W     = 32;
  localparam int NUM_WB_REQ = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    word_t     data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves to the granted index only when update_en is high.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] gnt,
  output logic       last_grant
);

  logic last_grant_q;
  logic last_grant_d;

  // On contention the requester that did not win last time is granted.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update_en) last_grant_d = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges the execute and load write-back streams onto the single regFile write port
// and keeps a pending-destination bitmap for hazard stalls.
module regfile_wb_arbiter
  import types_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic      [NUM_REQ-1:0]     req_valid,
  input  reg_addr_t [NUM_REQ-1:0]     req_rd,
  input  word_t     [NUM_REQ-1:0]     req_data,
  output logic      [NUM_REQ-1:0]     req_ready,
  input  logic                        resv_valid,
  input  reg_addr_t                   resv_rd,
  output logic      [REG_COUNT-1:0]   busy,
  output logic                        wb_we,
  output reg_addr_t                   wb_addr,
  output word_t                       wb_data
);

  // Handshake: a requester's write is taken in any cycle where req_valid[i] && req_ready[i];
  // req_ready is a combinational grant and at most one bit is ever high.

  logic           handshake;
  logic           sel;
  reg_addr_t      sel_rd;
  word_t          sel_data;
  logic           commit;
  logic           last_grant;

  logic           wb_we_q,   wb_we_d;
  reg_addr_t      wb_addr_q, wb_addr_d;
  word_t          wb_data_q, wb_data_d;
  logic [REG_COUNT-1:0] busy_q, busy_d;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req_valid[1:0]),
    .update_en  (handshake),
    .gnt        (req_ready[1:0]),
    .last_grant (last_grant)
  );

  always_comb begin
    handshake = |(req_valid & req_ready);
    sel       = req_ready[1];
    sel_rd    = req_rd[sel];
    sel_data  = req_data[sel];
    // Writes to x0 complete the handshake but never reach the register file.
    commit    = handshake && (sel_rd != '0);
  end

  always_comb begin
    wb_we_d   = commit;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (commit) begin
      wb_addr_d = sel_rd;
      wb_data_d = sel_data;
    end
  end

  // A same-cycle reservation overrides the clear: a newer write is still outstanding.
  always_comb begin
    busy_d = busy_q;
    if (commit) busy_d[sel_rd] = 1'b0;
    if (resv_valid && (resv_rd != '0)) busy_d[resv_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign busy    = busy_q;

endmodule
